// File: rtl/parallel_mul.sv
// parallel_mul: 3-stage pipelined unsigned multiplier (clk; rstn async active-low; In1/In2 operands; Out registered 2*WIDTH product)
module parallel_mul #(
  parameter int WIDTH = 1024,
  parameter int LIMB = 64
) (
  input logic clk,
  input logic rstn,
  input logic [WIDTH-1:0] In1,
  input logic [WIDTH-1:0] In2,
  output logic [2*WIDTH-1:0] Out
);
  localparam int N = WIDTH / LIMB;
  localparam int PW = WIDTH + LIMB;
  logic [WIDTH-1:0] a_q, b_q;
  logic [PW-1:0] pp [N];
  logic [2*WIDTH-1:0] t0 [N];
  logic [2*WIDTH-1:0] t1 [N/2];
  logic [2*WIDTH-1:0] t2 [N/4];
  logic [2*WIDTH-1:0] t3 [N/8];
  logic [2*WIDTH-1:0] sum;
  always_comb begin
    for (int k = 0; k < N; k++) t0[k] = {{(WIDTH-LIMB){1'b0}}, pp[k]} << (LIMB*k);
    for (int k = 0; k < N/2; k++) t1[k] = t0[2*k] + t0[2*k+1];
    for (int k = 0; k < N/4; k++) t2[k] = t1[2*k] + t1[2*k+1];
    for (int k = 0; k < N/8; k++) t3[k] = t2[2*k] + t2[2*k+1];
    sum = t3[0] + t3[1];
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      a_q <= '0;
      b_q <= '0;
      for (int k = 0; k < N; k++) pp[k] <= '0;
      Out <= '0;
    end else begin
      a_q <= In1;
      b_q <= In2;
      for (int k = 0; k < N; k++) pp[k] <= {{LIMB{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q[k*LIMB +: LIMB]};
      Out <= sum;
    end
endmodule

// File: tb/tb_parallel_mul.sv
// tb_parallel_mul: scoreboard bench for parallel_mul
module tb_parallel_mul;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [1023:0] in1, in2;
  logic [2047:0] out_w;
  logic [2047:0] sb [$];
  logic [2047:0] c;
  int checks = 0;
  int errors = 0;
  parallel_mul dut (.clk(clk), .rstn(rstn), .In1(in1), .In2(in2), .Out(out_w));
  always #5 clk = ~clk;
  function automatic logic [2047:0] mul(input logic [1023:0] a, input logic [1023:0] b);
    return {1024'b0, a} * {1024'b0, b};
  endfunction
  function automatic logic [1023:0] rnd();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  task automatic chk(input string tag, input logic [2047:0] e);
    checks++;
    assert (out_w === e) else begin
      errors++;
      $error("FAIL %s: Out[127:0]=%h expected[127:0]=%h Out[2047:1920]=%h expected[2047:1920]=%h", tag, out_w[127:0], e[127:0], out_w[2047:1920], e[2047:1920]);
    end
  endtask
  task automatic sb_reset();
    sb.delete();
    sb.push_back('0);
    sb.push_back('0);
  endtask
  task automatic step(input string tag);
    logic [2047:0] e;
    @(posedge clk);
    if (rstn) begin
      sb.push_back(mul(in1, in2));
      e = sb.pop_front();
    end else e = '0;
    #1;
    chk(tag, e);
  endtask
  initial begin
    in1 = 1024'd44;
    in2 = 1024'd55;
    sb_reset();
    repeat (5) step("reset_hold");
    rstn = 1'b1;
    repeat (1000) step("hold_44_55");
    chk("const_2420", 2048'd2420);
    in2 = 1024'd33;
    repeat (1000) step("hold_44_33");
    chk("const_1452", 2048'd1452);
    in1 = 1024'd4345;
    in2 = 1024'd45345;
    repeat (1000) step("hold_4345_45345");
    chk("const_197024025", 2048'd197024025);
    in1 = '0;
    in2 = '1;
    repeat (4) step("zero_x_ones");
    chk("const_zero", '0);
    in1 = 1024'd1;
    in2 = rnd();
    repeat (4) step("one_x_rand");
    chk("identity", {1024'b0, in2});
    in1 = '1;
    in2 = '1;
    repeat (4) step("ones_x_ones");
    c = {{1023{1'b1}}, {1024{1'b0}}, 1'b1};
    chk("const_max", c);
    in1 = '0;
    in1[63:0] = '1;
    in2 = '0;
    in2[1023] = 1'b1;
    in2[63:0] = '1;
    repeat (4) step("limb_carry");
    in1 = '0;
    in1[1023] = 1'b1;
    in2 = in1;
    repeat (4) step("top_bits");
    c = '0;
    c[2046] = 1'b1;
    chk("const_2_2046", c);
    for (int i = 0; i < 200; i++) begin
      in1 = rnd();
      in2 = rnd();
      step("stream");
    end
    for (int i = 0; i < 10; i++) begin
      in1 = rnd();
      in2 = rnd();
      step("pre_reset");
    end
    #1 rstn = 1'b0;
    #1 chk("async_clear", '0);
    sb_reset();
    for (int i = 0; i < 3; i++) begin
      in1 = rnd();
      in2 = rnd();
      step("in_reset");
    end
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in1 = rnd();
      in2 = rnd();
      step("post_reset");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
